dmem_ctrl: RTL and testbench

Single-port data memory with a request/response handshake. It sits directly downstream of the pipeline's memory stage. It consumes the core's to-mem request bundle (valid, wen, byte_not_word, write_data, yumi) plus the 32-bit data address. It produces the from-mem bundle (yumi, valid, read_data) with a fixed, parameterised access latency. It supports word and byte loads and stores and flags out-of-range accesses.

---
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Single-port 32-bit data memory with word/byte access and a sticky out-of-range flag.
// Latency: response valid latency_p cycles after the accepting cycle; array read and written at accept.
// Backpressure: response is held until yumi_i; new requests are accepted only in IDLE.
module dmem_ctrl #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        wen_i,
    input  logic        byte_not_word_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        yumi_i,
    output logic        yumi_o,
    output logic        valid_o,
    output logic [31:0] read_data_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int         words_lp    = 1 << addr_width_p;
    localparam logic [3:0] cnt_init_lp = (latency_p > 1) ? 4'(latency_p - 2) : 4'd0;

    state_e                  state_r, state_n;
    logic [3:0]              cnt_r, cnt_n;
    logic [31:0]             mem_r [words_lp];
    logic [31:0]             rdata_r;
    logic                    error_r;
    logic                    accept;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic                    out_of_range;
    logic [31:0]             mem_word;
    logic [7:0]              lane_byte;
    logic [31:0]             load_data;
    logic [31:0]             wr_data;
    logic [3:0]              wr_be;

    assign word_idx     = addr_i[addr_width_p+1:2];
    assign lane         = addr_i[1:0];
    // Any address bit above the array's byte range marks the access out of range.
    assign out_of_range = |(addr_i >> (addr_width_p + 2));
    assign mem_word     = mem_r[word_idx];
    assign lane_byte    = mem_word[{lane, 3'b000} +: 8];
    assign accept       = yumi_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept) begin
                    state_n = (latency_p == 1) ? RESP : WAIT;
                    cnt_n   = cnt_init_lp;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) state_n = RESP;
                else               cnt_n   = cnt_r - 4'd1;
            end
            RESP: begin
                if (yumi_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        yumi_o  = 1'b0;
        valid_o = 1'b0;
        if (reset && (state_r == IDLE)) yumi_o = valid_i;
        if (state_r == RESP)            valid_o = 1'b1;
    end

    always_comb begin
        load_data = 32'd0;
        if (!wen_i && !out_of_range)
            load_data = byte_not_word_i ? {24'd0, lane_byte} : mem_word;
        wr_be   = byte_not_word_i ? (4'b0001 << lane) : 4'b1111;
        wr_data = byte_not_word_i ? {4{write_data_i[7:0]}} : write_data_i;
    end

    // The array has no reset: contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (accept && wen_i && !out_of_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_r[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_r <= 32'd0;
            error_r <= 1'b0;
        end else if (accept) begin
            rdata_r <= load_data;
            if (out_of_range) error_r <= 1'b1;
        end
    end

    assign read_data_o = rdata_r;
    assign error_o     = error_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: instance a (addr_width_p=10, latency_p=2), instance b (addr_width_p=8, latency_p=1).
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        vld   [2];
    logic        wen   [2];
    logic        bnw   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        yumi  [2];

    logic        yumi_o_a, valid_o_a, err_a;
    logic        yumi_o_b, valid_o_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int total = 0;
    int bad   = 0;

    dmem_ctrl #(.addr_width_p(10), .latency_p(2)) u_a (
        .clk(clk), .reset(rst_n[0]), .valid_i(vld[0]), .wen_i(wen[0]),
        .byte_not_word_i(bnw[0]), .addr_i(addr[0]), .write_data_i(wdata[0]),
        .yumi_i(yumi[0]), .yumi_o(yumi_o_a), .valid_o(valid_o_a),
        .read_data_o(rdata_a), .error_o(err_a)
    );

    dmem_ctrl #(.addr_width_p(8), .latency_p(1)) u_b (
        .clk(clk), .reset(rst_n[1]), .valid_i(vld[1]), .wen_i(wen[1]),
        .byte_not_word_i(bnw[1]), .addr_i(addr[1]), .write_data_i(wdata[1]),
        .yumi_i(yumi[1]), .yumi_o(yumi_o_b), .valid_o(valid_o_b),
        .read_data_o(rdata_b), .error_o(err_b)
    );

    // One full transaction; clobbers request fields after accept to show they are not re-sampled.
    task automatic do_req(input int d, input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] wd, output logic acc, output int lat,
                          output logic [31:0] rd, output logic clr);
        @(negedge clk);
        vld[d] = 1'b1; wen[d] = w; bnw[d] = b; addr[d] = a; wdata[d] = wd;
        #1 acc = (d == 0) ? yumi_o_a : yumi_o_b;
        lat = 0;
        do begin
            @(negedge clk);
            vld[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd; bnw[d] = ~b;
            lat++;
        end while (!((d == 0) ? valid_o_a : valid_o_b) && lat < 20);
        rd = (d == 0) ? rdata_a : rdata_b;
        yumi[d] = 1'b1;
        @(negedge clk);
        yumi[d] = 1'b0;
        clr = !((d == 0) ? valid_o_a : valid_o_b);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin rst_n[d] = 1'b0; vld[d] = 1'b1; end
        @(negedge clk);
        @(negedge clk);
        total++; if ({valid_o_a, err_a, yumi_o_a} !== 3'b000) begin bad++; $display("FAIL reset_a_flags: got %b want 000", {valid_o_a, err_a, yumi_o_a}); end
        total++; if (rdata_a !== 32'd0) begin bad++; $display("FAIL reset_a_rdata: got %h want 0", rdata_a); end
        total++; if ({valid_o_b, err_b, yumi_o_b} !== 3'b000) begin bad++; $display("FAIL reset_b_flags: got %b want 000", {valid_o_b, err_b, yumi_o_b}); end
        total++; if (rdata_b !== 32'd0) begin bad++; $display("FAIL reset_b_rdata: got %h want 0", rdata_b); end
        for (int d = 0; d < 2; d++) begin rst_n[d] = 1'b1; vld[d] = 1'b0; end
        @(negedge clk);
    endtask

    task automatic test_word();
        logic acc, clr; int lat; logic [31:0] rd;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, acc, lat, rd, clr);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL word_st_accept: got %b want 1", acc); end
        total++; if (lat != 2) begin bad++; $display("FAIL word_st_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL word_st_rdata: got %h want 0", rd); end
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL word_st_valid_drop: got %b want 1", clr); end
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, clr);
        total++; if (lat != 2) begin bad++; $display("FAIL word_ld_latency: got %0d want 2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_ld_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte();
        logic acc, clr; int lat; logic [31:0] rd;
        do_req(0, 1'b1, 1'b1, 32'h11, 32'hFFFFFFAB, acc, lat, rd, clr);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL byte_st_rdata: got %h want 0", rd); end
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'hDEADABEF) begin bad++; $display("FAIL byte_ld_w10: got %h want deadabef", rd); end
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL byte_ld_b13: got %h want 000000de", rd); end
        do_req(0, 1'b0, 1'b1, 32'h11, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'h000000AB) begin bad++; $display("FAIL byte_ld_b11: got %h want 000000ab", rd); end
        do_req(0, 1'b0, 1'b0, 32'h12, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'hDEADABEF) begin bad++; $display("FAIL byte_ld_w12: got %h want deadabef", rd); end
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        @(negedge clk);
        vld[0] = 1'b1; wen[0] = 1'b0; bnw[0] = 1'b0; addr[0] = 32'h10;
        #1;
        total++; if (yumi_o_a !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", yumi_o_a); end
        @(negedge clk);
        bnw[0] = 1'b1; addr[0] = 32'h13;
        #1;
        total++; if ({yumi_o_a, valid_o_a} !== 2'b00) begin bad++; $display("FAIL bp_wait: yumi_o,valid_o got %b want 00", {yumi_o_a, valid_o_a}); end
        @(negedge clk);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (valid_o_a !== 1'b1 || yumi_o_a !== 1'b0 || rdata_a !== 32'hDEADABEF) hold_ok = 1'b0;
            @(negedge clk);
        end
        total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL bp_hold: got %b want 1 (last valid_o=%b yumi_o=%b rdata=%h)", hold_ok, valid_o_a, yumi_o_a, rdata_a); end
        yumi[0] = 1'b1;
        #1;
        total++; if ({valid_o_a, yumi_o_a} !== 2'b10) begin bad++; $display("FAIL bp_release: valid_o,yumi_o got %b want 10", {valid_o_a, yumi_o_a}); end
        @(negedge clk);
        yumi[0] = 1'b0;
        #1;
        total++; if ({valid_o_a, yumi_o_a} !== 2'b01) begin bad++; $display("FAIL bp_pending_accept: valid_o,yumi_o got %b want 01", {valid_o_a, yumi_o_a}); end
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        total++; if (valid_o_a !== 1'b1 || rdata_a !== 32'h000000DE) begin bad++; $display("FAIL bp_pending_resp: valid_o=%b rdata=%h want 1/000000de", valid_o_a, rdata_a); end
        yumi[0] = 1'b1;
        @(negedge clk);
        yumi[0] = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic acc, clr; int lat; logic [31:0] rd;
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL oor_a_pre: got %b want 0", err_a); end
        do_req(0, 1'b1, 1'b0, 32'h1010, 32'h12345678, acc, lat, rd, clr);
        total++; if (acc !== 1'b1 || lat != 2 || rd !== 32'd0) begin bad++; $display("FAIL oor_a_resp: acc=%b lat=%0d rdata=%h want 1/2/0", acc, lat, rd); end
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL oor_a_err: got %b want 1", err_a); end
        do_req(0, 1'b0, 1'b0, 32'h1010, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL oor_a_load: got %h want 0", rd); end
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'hDEADABEF || err_a !== 1'b1) begin bad++; $display("FAIL oor_a_nowrap: rdata=%h err=%b want deadabef/1", rd, err_a); end

        do_req(1, 1'b1, 1'b0, 32'h0, 32'h11223344, acc, lat, rd, clr);
        total++; if (lat != 1 || err_b !== 1'b0) begin bad++; $display("FAIL oor_b_inrange: lat=%0d err=%b want 1/0", lat, err_b); end
        do_req(1, 1'b1, 1'b0, 32'h400, 32'h12345678, acc, lat, rd, clr);
        total++; if (acc !== 1'b1 || lat != 1 || rd !== 32'd0 || clr !== 1'b1) begin bad++; $display("FAIL oor_b_resp: acc=%b lat=%0d rdata=%h clr=%b want 1/1/0/1", acc, lat, rd, clr); end
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL oor_b_err: got %b want 1", err_b); end
        do_req(1, 1'b0, 1'b0, 32'h0, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'h11223344 || err_b !== 1'b1) begin bad++; $display("FAIL oor_b_nowrap: rdata=%h err=%b want 11223344/1", rd, err_b); end
    endtask

    task automatic test_mid_reset();
        logic acc, clr, quiet; int lat; logic [31:0] rd;
        @(negedge clk);
        vld[0] = 1'b1; wen[0] = 1'b0; bnw[0] = 1'b0; addr[0] = 32'h10;
        @(negedge clk);
        vld[0] = 1'b0; rst_n[0] = 1'b0;
        @(negedge clk);
        total++; if ({valid_o_a, err_a} !== 2'b00 || rdata_a !== 32'd0) begin bad++; $display("FAIL midrst_state: valid_o=%b err=%b rdata=%h want 0/0/0", valid_o_a, err_a, rdata_a); end
        rst_n[0] = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid_o_a !== 1'b0) quiet = 1'b0;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL midrst_no_resp: got %b want 1", quiet); end
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, acc, lat, rd, clr);
        total++; if (rd !== 32'hDEADABEF || lat != 2) begin bad++; $display("FAIL midrst_retained: rdata=%h lat=%0d want deadabef/2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic exp_y, exp_v;
        @(negedge clk);
        yumi[1] = 1'b1; vld[1] = 1'b1; wen[1] = 1'b0; bnw[1] = 1'b0; addr[1] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_y = (c % 2 == 0);
            exp_v = (c % 2 == 1);
            total++; if ({yumi_o_b, valid_o_b} !== {exp_y, exp_v}) begin bad++; $display("FAIL b2b_cycle%0d: yumi_o,valid_o got %b want %b", c, {yumi_o_b, valid_o_b}, {exp_y, exp_v}); end
            if (exp_v) begin
                total++; if (rdata_b !== 32'h11223344) begin bad++; $display("FAIL b2b_rdata%0d: got %h want 11223344", c, rdata_b); end
            end
            @(negedge clk);
        end
        vld[1] = 1'b0;
        @(negedge clk);
        yumi[1] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; vld[d] = 1'b0; wen[d] = 1'b0; bnw[d] = 1'b0;
            addr[d] = 32'd0; wdata[d] = 32'd0; yumi[d] = 1'b0;
        end
        test_reset();
        test_word();
        test_byte();
        test_backpressure();
        test_out_of_range();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
